// File: rtl/ocr_bridge_config_pkg.sv
// Shared widths and state encoding for the OCR bridge receive path.
package ocr_bridge_config_pkg;
  localparam int PIO_DATA_WIDTH = 128;
  localparam int UINT8_WIDTH    = 8;
  localparam int RX_WD_DEPTH    = 8;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_WAIT    = 2'd1,
    RX_DONE    = 2'd2,
    RX_TIMEOUT = 2'd3
  } rx_state_t;
endpackage

// File: rtl/rx_unit_if.sv
// PIO-side write port and FIFO-side push port of the receive engine.
interface rx_unit_if
  import ocr_bridge_config_pkg::*;
#(
  parameter int DATA_W = PIO_DATA_WIDTH
);
  logic [DATA_W-1:0] pio_out;
  logic              pio_valid;
  logic              fifo_full;
  logic              block_write;
  logic              push;
  logic [DATA_W-1:0] data_out;

  // master = HPS/PIO block plus downstream FIFO; slave = rx_unit
  modport master (
    output pio_out, pio_valid, fifo_full,
    input  block_write, push, data_out
  );
  modport slave (
    input  pio_out, pio_valid, fifo_full,
    output block_write, push, data_out
  );
endinterface

// File: rtl/rx_watchdog.sv
// Idle-gap counter: expires after exactly conf enabled cycles without a kick.
module rx_watchdog
  import ocr_bridge_config_pkg::*;
#(
  parameter int WD_W = RX_WD_DEPTH
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic            kick,
  input  logic [WD_W-1:0] conf,
  output logic            expired
);
  logic [WD_W-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (reset || clr || kick) cnt <= '0;
    else if (en)              cnt <= cnt + 1'b1;
  end

  // cnt==conf-1 on an enabled cycle means this is the conf-th idle cycle
  assign expired = en && !kick && (conf != '0) && (cnt == conf - WD_W'(1));
endmodule

// File: rtl/rx_unit.sv
// HPS->FPGA receive engine: forwards PIO writes into the input FIFO, counts
// them against a headcount and supervises inter-word gaps.
module rx_unit
  import ocr_bridge_config_pkg::*;
#(
  parameter int DATA_W = PIO_DATA_WIDTH,
  parameter int WD_W   = RX_WD_DEPTH,
  parameter int CNT_W  = UINT8_WIDTH
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             Clear_buff,
  input  logic             rx_en,
  input  logic [CNT_W-1:0] headcount,
  input  logic [WD_W-1:0]  watchdog_rx_conf,
  rx_unit_if.slave         bus,
  output logic [CNT_W-1:0] rx_count,
  output logic             rx_done,
  output logic             watchdog_rx_trigger,
  output logic             rx_overrun
);
  rx_state_t         state;
  logic [CNT_W-1:0]  hc_latched;
  logic              block_write;
  logic              accept;
  logic              wd_kick;
  logic              wd_expired;
  logic              push;
  logic [DATA_W-1:0] data_out;

  assign block_write     = (state == RX_WAIT) ? bus.fifo_full : 1'b1;
  assign accept          = (state == RX_WAIT) && bus.pio_valid && !bus.fifo_full;
  assign wd_kick         = accept || (state != RX_WAIT);
  assign bus.block_write = block_write;
  assign bus.push        = push;
  assign bus.data_out    = data_out;

  rx_watchdog #(.WD_W(WD_W)) u_wd (
    .clk_in  (clk_in),
    .reset   (reset),
    .clr     (Clear_buff),
    .en      (!bus.fifo_full),
    .kick    (wd_kick),
    .conf    (watchdog_rx_conf),
    .expired (wd_expired)
  );

  always_ff @(posedge clk_in) begin
    if (reset || Clear_buff) begin
      state               <= RX_IDLE;
      hc_latched          <= '0;
      push                <= 1'b0;
      data_out            <= '0;
      rx_count            <= '0;
      rx_done             <= 1'b0;
      watchdog_rx_trigger <= 1'b0;
      rx_overrun          <= 1'b0;
    end else begin
      push <= 1'b0;
      if (bus.pio_valid && block_write) rx_overrun <= 1'b1;

      case (state)
        RX_IDLE: begin
          if (rx_en) begin
            rx_count <= '0;
            if (headcount == '0) begin
              state   <= RX_DONE;
              rx_done <= 1'b1;
            end else begin
              hc_latched <= headcount;
              state      <= RX_WAIT;
            end
          end
        end
        RX_WAIT: begin
          // abort wins over a same-cycle write; accept wins over expiry
          if (!rx_en) begin
            state <= RX_IDLE;
          end else if (accept) begin
            push     <= 1'b1;
            data_out <= bus.pio_out;
            rx_count <= rx_count + 1'b1;
            if (rx_count + CNT_W'(1) == hc_latched) begin
              state   <= RX_DONE;
              rx_done <= 1'b1;
            end
          end else if (wd_expired) begin
            state               <= RX_TIMEOUT;
            watchdog_rx_trigger <= 1'b1;
          end
        end
        RX_DONE: begin
          if (!rx_en) begin
            state   <= RX_IDLE;
            rx_done <= 1'b0;
          end
        end
        RX_TIMEOUT: begin
          if (!rx_en) begin
            state               <= RX_IDLE;
            watchdog_rx_trigger <= 1'b0;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_unit.sv
// Directed bench for rx_unit: normal frame, watchdog, back-pressure, empty
// frame, abort, and reset/Clear_buff against a same-cycle write.
module tb_rx_unit;
  import ocr_bridge_config_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Clear_buff = 1'b0;
  logic       rx_en = 1'b0;
  logic [7:0] headcount = '0;
  logic [7:0] wd_conf = '0;
  logic [7:0] rx_count;
  logic       rx_done, trig, ovr;
  int         n_chk = 0, n_bad = 0, n_push = 0;
  int         base;

  rx_unit_if bus ();

  rx_unit dut (
    .clk_in              (clk),
    .reset               (reset),
    .Clear_buff          (Clear_buff),
    .rx_en               (rx_en),
    .headcount           (headcount),
    .watchdog_rx_conf    (wd_conf),
    .bus                 (bus),
    .rx_count            (rx_count),
    .rx_done             (rx_done),
    .watchdog_rx_trigger (trig),
    .rx_overrun          (ovr)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (bus.push === 1'b1) n_push++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] word(input int w);
    return {32'hC0DE0000 + 32'(w), 32'h12345678 ^ 32'(w), ~32'(w), 32'h0F0F0000 | 32'(w)};
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bw"},   bus.block_write, 1);
    chk({tag, "_push"}, bus.push, 0);
    chk({tag, "_data"}, bus.data_out, 0);
    chk({tag, "_cnt"},  rx_count, 0);
    chk({tag, "_done"}, rx_done, 0);
    chk({tag, "_trig"}, trig, 0);
    chk({tag, "_ovr"},  ovr, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int early, bw_bad, trig_bad;
    bus.pio_out   = '0;
    bus.pio_valid = 1'b0;
    bus.fifo_full = 1'b0;
    step; step;
    chk_reset_vals("rst");
    reset = 1'b0;

    // 1: four words spaced 3 cycles
    headcount = 8'd4; wd_conf = 8'd20; rx_en = 1'b1;
    step;
    chk("t1_bw_wait", bus.block_write, 0);
    base = n_push;
    for (int w = 0; w < 4; w++) begin
      bus.pio_valid = 1'b1; bus.pio_out = word(w);
      step;
      bus.pio_valid = 1'b0;
      chk("t1_push", bus.push, 1);
      chk("t1_data", bus.data_out, word(w));
      chk("t1_cnt", rx_count, w + 1);
      chk("t1_done", rx_done, (w == 3));
      if (w < 3) begin
        step;
        chk("t1_push_off", bus.push, 0);
        step;
      end
    end
    step;
    chk("t1_npush", n_push - base, 4);
    chk("t1_bw_done", bus.block_write, 1);
    rx_en = 1'b0;
    step;
    chk("t1_done_clr", rx_done, 0);

    // 2: one word then silence -> trigger exactly 10 cycles after the accept
    headcount = 8'd3; wd_conf = 8'd10; rx_en = 1'b1;
    step;
    bus.pio_valid = 1'b1; bus.pio_out = word(10);
    step;
    bus.pio_valid = 1'b0;
    chk("t2_push", bus.push, 1);
    early = 0;
    for (int i = 0; i < 9; i++) begin
      step;
      if (trig !== 1'b0) early++;
    end
    chk("t2_early", early, 0);
    step;
    chk("t2_trig", trig, 1);
    chk("t2_done", rx_done, 0);
    chk("t2_cnt", rx_count, 1);
    chk("t2_bw", bus.block_write, 1);
    rx_en = 1'b0;
    step;
    chk("t2_trig_clr", trig, 0);

    // 3: fifo_full for 30 cycles mid-frame
    headcount = 8'd2; wd_conf = 8'd10; rx_en = 1'b1;
    step;
    base = n_push;
    bus.pio_valid = 1'b1; bus.pio_out = word(20);
    step;
    bus.pio_valid = 1'b0;
    bus.fifo_full = 1'b1;
    bw_bad = 0; trig_bad = 0;
    for (int i = 0; i < 30; i++) begin
      bus.pio_valid = (i == 15); bus.pio_out = word(21);
      #1;
      if (bus.block_write !== 1'b1) bw_bad++;
      step;
      if (trig !== 1'b0) trig_bad++;
    end
    bus.pio_valid = 1'b0;
    chk("t3_bw_window", bw_bad, 0);
    chk("t3_no_trig", trig_bad, 0);
    chk("t3_ovr", ovr, 1);
    chk("t3_npush_window", n_push - base, 1);
    chk("t3_cnt_window", rx_count, 1);
    bus.fifo_full = 1'b0;
    #1;
    chk("t3_bw_release", bus.block_write, 0);
    bus.pio_valid = 1'b1; bus.pio_out = word(22);
    step;
    bus.pio_valid = 1'b0;
    chk("t3_push", bus.push, 1);
    chk("t3_data", bus.data_out, word(22));
    chk("t3_done", rx_done, 1);
    chk("t3_cnt", rx_count, 2);
    rx_en = 1'b0;
    step;

    // 4: empty frame
    base = n_push;
    headcount = 8'd0; rx_en = 1'b1;
    step;
    chk("t4_done", rx_done, 1);
    chk("t4_cnt", rx_count, 0);
    step;
    chk("t4_npush", n_push - base, 0);
    rx_en = 1'b0;
    step;
    chk("t4_done_clr", rx_done, 0);

    // 5: abort after 2 of 5, watchdog disabled
    headcount = 8'd5; wd_conf = 8'd0; rx_en = 1'b1;
    step;
    for (int w = 0; w < 2; w++) begin
      bus.pio_valid = 1'b1; bus.pio_out = word(30 + w);
      step;
      bus.pio_valid = 1'b0;
      step; step;
    end
    for (int i = 0; i < 20; i++) step;
    chk("t5_wd_off", trig, 0);
    rx_en = 1'b0;
    step;
    chk("t5_done", rx_done, 0);
    chk("t5_bw", bus.block_write, 1);
    chk("t5_cnt", rx_count, 2);

    // 6a: reset in WAIT with a coincident strobe
    headcount = 8'd3; wd_conf = 8'd20; rx_en = 1'b1;
    step;
    base = n_push;
    bus.pio_valid = 1'b1; bus.pio_out = word(40); reset = 1'b1;
    step;
    bus.pio_valid = 1'b0; reset = 1'b0;
    chk_reset_vals("t6_rst");
    step;
    // 6b: Clear_buff in WAIT with a coincident strobe
    bus.fifo_full = 1'b1; bus.pio_valid = 1'b1; bus.pio_out = word(41);
    step;
    bus.fifo_full = 1'b0; bus.pio_valid = 1'b0;
    chk("t6_ovr_set", ovr, 1);
    bus.pio_valid = 1'b1; bus.pio_out = word(42);
    step;
    bus.pio_valid = 1'b0;
    chk("t6_push", bus.push, 1);
    chk("t6_cnt", rx_count, 1);
    bus.pio_valid = 1'b1; bus.pio_out = word(43); Clear_buff = 1'b1;
    step;
    bus.pio_valid = 1'b0; Clear_buff = 1'b0;
    chk_reset_vals("t6_clr");
    rx_en = 1'b0;
    step; step;
    chk("t6_npush", n_push - base, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
